// File: rtl/tj_seq_trigger_pkg.sv
// Shared constants for the plaintext-sequence trigger: the pattern table,
// the FSM state type and the idle-counter width.
package tj_pkg;

  localparam int unsigned TJ_IDLE_CNT_W = 16;

  // Trigger sequence. Entries 4..7 are reserved.
  localparam logic [127:0] SEQ_PAT [8] = '{
    128'h3243f6a8885a308d313198a2e0370734,
    128'h00112233445566778899aabbccddeeff,
    128'h00000000000000000000000000000000,
    128'hffffffffffffffffffffffffffffffff,
    {4{32'hdeadbeef}},
    {4{32'hdeadbeef}},
    {4{32'hdeadbeef}},
    {4{32'hdeadbeef}}
  };

  typedef enum logic {
    TJ_IDLE,
    TJ_FIRE
  } tj_state_t;

endpackage

// File: rtl/tj_seq_trigger_if.sv
// Plaintext tap and trigger outputs of tj_seq_trigger.
interface tj_seq_trigger_if #(
  parameter int unsigned SEQ_LEN = 4
);
  localparam int unsigned IDX_W = $clog2(SEQ_LEN + 1);

  logic             data_valid;
  logic [127:0]     data;
  logic             Tj_Trig;
  logic [IDX_W-1:0] seq_idx;

  modport master (output data_valid, output data, input Tj_Trig, input seq_idx);
  modport slave  (input data_valid, input data, output Tj_Trig, output seq_idx);
endinterface

// File: rtl/tj_seq_trigger_hold_counter.sv
// Loadable down-counter; done is high during the cycle the count equals 1,
// so a load of N yields done in the N-th cycle after the load edge.
// A load of 0 never produces done.
module tj_hold_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;

  // Load on request, otherwise count down to zero and stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == W'(1));
endmodule

// File: rtl/tj_seq_trigger.sv
// Watches the plaintext stream for the ordered sequence SEQ_PAT[0..SEQ_LEN-1]
// and raises Tj_Trig one cycle after the final matching beat.
// Optional macro TJ_TIMEOUT_EN: drops a partial match after TIMEOUT idle cycles.
module tj_seq_trigger
  import tj_pkg::*;
#(
  parameter int unsigned SEQ_LEN     = 4,
  parameter int unsigned HOLD_CYCLES = 0,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  tj_seq_trigger_if.slave  bus
);
  localparam int unsigned IDX_W  = $clog2(SEQ_LEN + 1);
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SEQ_LEN - 1);

  if (SEQ_LEN < 2 || SEQ_LEN > 8) begin : g_bad_seq_len
    $error("tj_seq_trigger: SEQ_LEN must be in 2..8");
  end
  if (TIMEOUT >= (1 << TJ_IDLE_CNT_W)) begin : g_bad_timeout
    $error("tj_seq_trigger: TIMEOUT exceeds idle counter range");
  end

  tj_state_t        state;
  logic [IDX_W-1:0] idx;
  logic             trig;
  logic             match_cur;
  logic             match_first;
  logic             fire_now;
  logic             hold_done;

  assign match_cur   = (bus.data == SEQ_PAT[3'(idx)]);
  assign match_first = (bus.data == SEQ_PAT[0]);
  assign fire_now    = (state == TJ_IDLE) && bus.data_valid && match_cur && (idx == LAST);

  // With HOLD_CYCLES=0 the counter is loaded with 0 and done never fires,
  // which keeps FIRE latched until reset without a separate code path.
  tj_hold_counter #(
    .W (HOLD_W)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (fire_now),
    .load_val (HOLD_W'(HOLD_CYCLES)),
    .done     (hold_done)
  );

`ifdef TJ_TIMEOUT_EN
  logic [TJ_IDLE_CNT_W-1:0] idle_cnt;
  logic                     idle_tick;
  logic                     timeout_hit;

  assign idle_tick   = !bus.data_valid && (idx != '0) && (state != TJ_FIRE);
  assign timeout_hit = (TIMEOUT != 0) && idle_tick &&
                       (idle_cnt == TJ_IDLE_CNT_W'(TIMEOUT - 1));

  // Idle-gap counter: cleared by any beat, advances only while partially matched.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (bus.data_valid || timeout_hit) begin
      idle_cnt <= '0;
    end else if (idle_tick) begin
      idle_cnt <= idle_cnt + TJ_IDLE_CNT_W'(1);
    end
  end
`endif

  // Sequence matcher and trigger FSM; outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TJ_IDLE;
      idx   <= '0;
      trig  <= 1'b0;
    end else begin
      case (state)
        TJ_IDLE: begin
          if (bus.data_valid) begin
            if (match_cur) begin
              if (idx == LAST) begin
                state <= TJ_FIRE;
                idx   <= IDX_W'(SEQ_LEN);
                trig  <= 1'b1;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end else begin
              idx <= match_first ? IDX_W'(1) : '0;
            end
          end
`ifdef TJ_TIMEOUT_EN
          else if (timeout_hit) begin
            idx <= '0;
          end
`endif
        end
        TJ_FIRE: begin
          if (hold_done) begin
            state <= TJ_IDLE;
            idx   <= '0;
            trig  <= 1'b0;
          end
        end
        default: begin
          state <= TJ_IDLE;
          idx   <= '0;
          trig  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Tj_Trig = trig;
  assign bus.seq_idx = idx;
endmodule
